// File: rtl/apple_spawn_ctrl.sv
// apple_spawn_ctrl: eat detection, score/win tracking and apple respawn.
// A free-running LFSR proposes respawn cells, each candidate is checked
// against the snake body store through a req/ack occupancy query, and a
// linear scan takes over once the random tries are used up.
module apple_spawn_ctrl #(
    parameter int          GRID_W    = 80,
    parameter int          GRID_H    = 60,
    parameter int          MAX_TRIES = 8,
    parameter int          WIN_SCORE = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       game_run,
    input  logic       move_tick,
    input  logic [6:0] head_x,
    input  logic [5:0] head_y,
    output logic       occ_req,
    output logic [6:0] occ_x,
    output logic [5:0] occ_y,
    input  logic       occ_ack,
    input  logic       occ_hit,
    output logic [6:0] apple_x,
    output logic [5:0] apple_y,
    output logic       apple_valid,
    output logic [3:0] score,
    output logic       eat_pulse,
    output logic       win,
    output logic       board_full
);

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_CHECK, S_SCAN, S_COMMIT, S_DONE, S_FULL
    } state_t;

    localparam logic [7:0]  W8     = 8'(GRID_W);
    localparam logic [6:0]  H7     = 7'(GRID_H);
    localparam logic [6:0]  X_LAST = 7'(GRID_W - 1);
    localparam logic [5:0]  Y_LAST = 6'(GRID_H - 1);
    localparam logic [13:0] CELLS  = 14'(GRID_W * GRID_H);
    localparam logic [3:0]  TRIES  = 4'(MAX_TRIES);
    localparam logic [3:0]  WIN_SC = 4'(WIN_SCORE);
    localparam logic [6:0]  RST_X  = 7'd15;
    localparam logic [5:0]  RST_Y  = 6'd33;

    state_t      r_state,       w_state_nxt;
    logic [3:0]  r_try_cnt,     w_try_cnt_nxt;
    logic [13:0] r_scan_cnt,    w_scan_cnt_nxt;
    logic [6:0]  r_cand_x,      w_cand_x_nxt;
    logic [5:0]  r_cand_y,      w_cand_y_nxt;
    logic        r_occ_req,     w_occ_req_nxt;
    logic [6:0]  r_occ_x,       w_occ_x_nxt;
    logic [5:0]  r_occ_y,       w_occ_y_nxt;
    logic [6:0]  r_apple_x,     w_apple_x_nxt;
    logic [5:0]  r_apple_y,     w_apple_y_nxt;
    logic        r_apple_valid, w_apple_valid_nxt;
    logic [3:0]  r_score,       w_score_nxt;
    logic        r_eat_pulse,   w_eat_pulse_nxt;
    logic        r_win,         w_win_nxt;
    logic        r_board_full,  w_board_full_nxt;

    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;
    logic [7:0]  w_raw_x;
    logic [6:0]  w_raw_y;
    logic [6:0]  w_rnd_x;
    logic [5:0]  w_rnd_y;
    logic [6:0]  w_scan_x;
    logic [5:0]  w_scan_y;
    logic [3:0]  w_score_inc;
    logic        w_eat;

    // Taps 16,14,13,11 map to bits 15,13,12,10.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Free-running LFSR; restart deliberately leaves it running unseeded.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!reset) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end

    // Fold the raw LFSR fields into the grid with one conditional subtract.
    assign w_raw_x = {1'b0, r_lfsr[6:0]};
    assign w_raw_y = {1'b0, r_lfsr[13:8]};
    assign w_rnd_x = (w_raw_x >= W8) ? 7'(w_raw_x - W8) : r_lfsr[6:0];
    assign w_rnd_y = (w_raw_y >= H7) ? 6'(w_raw_y - H7) : r_lfsr[13:8];

    // Raster-order successor of the current candidate, wrapping at both edges.
    assign w_scan_x = (r_cand_x == X_LAST) ? 7'd0 : r_cand_x + 7'd1;
    assign w_scan_y = (r_cand_x != X_LAST) ? r_cand_y :
                      (r_cand_y == Y_LAST) ? 6'd0 : r_cand_y + 6'd1;

    assign w_score_inc = r_score + 4'd1;
    assign w_eat = move_tick & game_run & r_apple_valid &
                   (head_x == r_apple_x) & (head_y == r_apple_y);

    // Next-state and next-output logic; restart overrides every state.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        w_state_nxt       = r_state;
        w_try_cnt_nxt     = r_try_cnt;
        w_scan_cnt_nxt    = r_scan_cnt;
        w_cand_x_nxt      = r_cand_x;
        w_cand_y_nxt      = r_cand_y;
        w_occ_req_nxt     = r_occ_req;
        w_occ_x_nxt       = r_occ_x;
        w_occ_y_nxt       = r_occ_y;
        w_apple_x_nxt     = r_apple_x;
        w_apple_y_nxt     = r_apple_y;
        w_apple_valid_nxt = r_apple_valid;
        w_score_nxt       = r_score;
        w_eat_pulse_nxt   = 1'b0;
        w_win_nxt         = r_win;
        w_board_full_nxt  = r_board_full;

        if (restart) begin
            w_state_nxt       = S_IDLE;
            w_try_cnt_nxt     = 4'd0;
            w_scan_cnt_nxt    = 14'd0;
            w_occ_req_nxt     = 1'b0;
            w_occ_x_nxt       = 7'd0;
            w_occ_y_nxt       = 6'd0;
            w_apple_x_nxt     = RST_X;
            w_apple_y_nxt     = RST_Y;
            w_apple_valid_nxt = 1'b1;
            w_score_nxt       = 4'd0;
            w_win_nxt         = 1'b0;
            w_board_full_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_eat) begin
                        w_eat_pulse_nxt   = 1'b1;
                        w_score_nxt       = w_score_inc;
                        w_apple_valid_nxt = 1'b0;
                        if (w_score_inc == WIN_SC) begin
                            w_win_nxt   = 1'b1;
                            w_state_nxt = S_DONE;
                        end else begin
                            w_try_cnt_nxt = 4'd0;
                            w_state_nxt   = S_GEN;
                        end
                    end
                end
                S_GEN: begin
                    w_cand_x_nxt  = w_rnd_x;
                    w_cand_y_nxt  = w_rnd_y;
                    w_try_cnt_nxt = r_try_cnt + 4'd1;
                    w_occ_req_nxt = 1'b1;
                    w_occ_x_nxt   = w_rnd_x;
                    w_occ_y_nxt   = w_rnd_y;
                    w_state_nxt   = S_CHECK;
                end
                S_CHECK: begin
                    if (occ_ack) begin
                        w_occ_req_nxt = 1'b0;
                        if (!occ_hit)               w_state_nxt = S_COMMIT;
                        else if (r_try_cnt < TRIES) w_state_nxt = S_GEN;
                        else                        w_state_nxt = S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Counter at CELLS means every cell was queried once.
                    if (r_scan_cnt == CELLS) begin
                        w_board_full_nxt = 1'b1;
                        w_state_nxt      = S_FULL;
                    end else begin
                        w_cand_x_nxt   = w_scan_x;
                        w_cand_y_nxt   = w_scan_y;
                        w_scan_cnt_nxt = r_scan_cnt + 14'd1;
                        w_occ_req_nxt  = 1'b1;
                        w_occ_x_nxt    = w_scan_x;
                        w_occ_y_nxt    = w_scan_y;
                        w_state_nxt    = S_CHECK;
                    end
                end
                S_COMMIT: begin
                    w_apple_x_nxt     = r_cand_x;
                    w_apple_y_nxt     = r_cand_y;
                    w_apple_valid_nxt = 1'b1;
                    w_scan_cnt_nxt    = 14'd0;
                    w_state_nxt       = S_IDLE;
                end
                S_DONE, S_FULL: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_try_cnt     <= 4'd0;
            r_scan_cnt    <= 14'd0;
            r_cand_x      <= 7'd0;
            r_cand_y      <= 6'd0;
            r_occ_req     <= 1'b0;
            r_occ_x       <= 7'd0;
            r_occ_y       <= 6'd0;
            r_apple_x     <= RST_X;
            r_apple_y     <= RST_Y;
            r_apple_valid <= 1'b1;
            r_score       <= 4'd0;
            r_eat_pulse   <= 1'b0;
            r_win         <= 1'b0;
            r_board_full  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_try_cnt     <= w_try_cnt_nxt;
            r_scan_cnt    <= w_scan_cnt_nxt;
            r_cand_x      <= w_cand_x_nxt;
            r_cand_y      <= w_cand_y_nxt;
            r_occ_req     <= w_occ_req_nxt;
            r_occ_x       <= w_occ_x_nxt;
            r_occ_y       <= w_occ_y_nxt;
            r_apple_x     <= w_apple_x_nxt;
            r_apple_y     <= w_apple_y_nxt;
            r_apple_valid <= w_apple_valid_nxt;
            r_score       <= w_score_nxt;
            r_eat_pulse   <= w_eat_pulse_nxt;
            r_win         <= w_win_nxt;
            r_board_full  <= w_board_full_nxt;
        end
    end

    assign occ_req     = r_occ_req;
    assign occ_x       = r_occ_x;
    assign occ_y       = r_occ_y;
    assign apple_x     = r_apple_x;
    assign apple_y     = r_apple_y;
    assign apple_valid = r_apple_valid;
    assign score       = r_score;
    assign eat_pulse   = r_eat_pulse;
    assign win         = r_win;
    assign board_full  = r_board_full;

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// tb_apple_spawn_ctrl: table-driven eat vectors with an expected-output
// queue, an LFSR reference model for respawn candidates, a reactive
// occupancy responder, and hand-written multi-cycle corner cases.
module tb_apple_spawn_ctrl;

    localparam int TB_W = 80;
    localparam int TB_H = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic       restart = 1'b0, game_run = 1'b0, move_tick = 1'b0;
    logic [6:0] head_x = '0;
    logic [5:0] head_y = '0;
    logic       occ_ack = 1'b0, occ_hit = 1'b0;
    logic       occ_req, apple_valid, eat_pulse, win, board_full;
    logic [6:0] occ_x, apple_x;
    logic [5:0] occ_y, apple_y;
    logic [3:0] score;

    // Small-grid instance for the board-full case: every query is a hit.
    logic       s_restart = 1'b0, s_game_run = 1'b0, s_move_tick = 1'b0;
    logic [6:0] s_head_x = '0;
    logic [5:0] s_head_y = '0;
    logic       s_occ_ack = 1'b1, s_occ_hit = 1'b1;
    logic       s_occ_req, s_apple_valid, s_eat_pulse, s_win, s_board_full;
    logic [6:0] s_occ_x, s_apple_x;
    logic [5:0] s_occ_y, s_apple_y;
    logic [3:0] s_score;

    apple_spawn_ctrl dut (
        .clk(clk), .reset(reset), .restart(restart), .game_run(game_run),
        .move_tick(move_tick), .head_x(head_x), .head_y(head_y),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
        .occ_ack(occ_ack), .occ_hit(occ_hit),
        .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
        .score(score), .eat_pulse(eat_pulse), .win(win), .board_full(board_full)
    );

    apple_spawn_ctrl #(.GRID_W(64), .GRID_H(32)) dut_s (
        .clk(clk), .reset(reset), .restart(s_restart), .game_run(s_game_run),
        .move_tick(s_move_tick), .head_x(s_head_x), .head_y(s_head_y),
        .occ_req(s_occ_req), .occ_x(s_occ_x), .occ_y(s_occ_y),
        .occ_ack(s_occ_ack), .occ_hit(s_occ_hit),
        .apple_x(s_apple_x), .apple_y(s_apple_y), .apple_valid(s_apple_valid),
        .score(s_score), .eat_pulse(s_eat_pulse), .win(s_win),
        .board_full(s_board_full)
    );

    // Reference LFSR (taps 16,14,13,11); m_prev is last cycle's value.
    logic [15:0] m_lfsr, m_prev;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_prev <= m_lfsr;
        end
    end

    function automatic logic [6:0] cand_x(input logic [15:0] l);
        int v;
        v = int'(l[6:0]);
        if (v >= TB_W) v -= TB_W;
        return 7'(v);
    endfunction

    function automatic logic [5:0] cand_y(input logic [15:0] l);
        int v;
        v = int'(l[13:8]);
        if (v >= TB_H) v -= TB_H;
        return 6'(v);
    endfunction

    function automatic logic [6:0] adv_x(input logic [6:0] x);
        return (int'(x) == TB_W - 1) ? 7'd0 : x + 7'd1;
    endfunction

    function automatic logic [5:0] adv_y(input logic [6:0] x, input logic [5:0] y);
        if (int'(x) != TB_W - 1) return y;
        return (int'(y) == TB_H - 1) ? 6'd0 : y + 6'd1;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected-output scoreboard for the cycle after each driven vector.
    typedef struct packed {
        logic       eat;
        logic [3:0] score;
        logic       valid;
    } exp_t;
    exp_t sb_q[$];

    function automatic exp_t mk_exp(input logic e, input int s, input logic v);
        exp_t r;
        r.eat   = e;
        r.score = 4'(s);
        r.valid = v;
        return r;
    endfunction

    // Responder state and query log for the main instance.
    int          rsp_delay = 0;
    int          rsp_wait = 0;
    int          rsp_hits_left = 0;
    bit          rsp_force_ack = 1'b0;
    int          q_count = 0;
    logic        req_prev = 1'b0;
    logic [15:0] rise_lfsr[$];
    logic [6:0]  rise_x[$];
    logic [5:0]  rise_y[$];
    int          s_q_count = 0;
    bit          s_watch = 1'b0;
    bit          s_valid_seen = 1'b0;

    // Advance one cycle, then sample and answer occupancy queries.
    task automatic tick();
        @(posedge clk);
        #1;
        if (occ_req) begin
            if (!req_prev) begin
                rise_lfsr.push_back(m_prev);
                rise_x.push_back(occ_x);
                rise_y.push_back(occ_y);
            end
            if (rsp_wait >= rsp_delay) begin
                occ_ack = 1'b1;
                occ_hit = (rsp_hits_left > 0);
                if (rsp_hits_left > 0) rsp_hits_left--;
                q_count++;
            end else begin
                occ_ack = 1'b0;
                occ_hit = 1'b0;
                rsp_wait++;
            end
        end else begin
            occ_ack  = 1'b0;
            occ_hit  = 1'b0;
            rsp_wait = 0;
        end
        if (rsp_force_ack) begin
            occ_ack = 1'b1;
            occ_hit = 1'b0;
        end
        req_prev = occ_req;
        if (s_occ_req) s_q_count++;
        if (s_watch && s_apple_valid) s_valid_seen = 1'b1;
    endtask

    // Drive one vector for a cycle and compare against the scoreboard head.
    task automatic apply(input logic [6:0] hx, input logic [5:0] hy,
                         input logic tk, input logic run, input exp_t e);
        exp_t got;
        head_x    = hx;
        head_y    = hy;
        move_tick = tk;
        game_run  = run;
        sb_q.push_back(e);
        tick();
        move_tick = 1'b0;
        got = sb_q.pop_front();
        check("eat_pulse", eat_pulse, got.eat);
        check("score", score, got.score);
        check("apple_valid", apple_valid, got.valid);
    endtask

    task automatic wait_apple(input int budget, output int cycles);
        cycles = 0;
        while (!apple_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        check("respawn_done", apple_valid, 1);
    endtask

    typedef struct {
        logic [6:0] hx;
        logic [5:0] hy;
        logic       tk;
        logic       run;
        exp_t       e;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        vecs[0] = '{7'd15, 6'd33, 1'b0, 1'b1, mk_exp(1'b0, 0, 1'b1)};
        vecs[1] = '{7'd15, 6'd33, 1'b1, 1'b0, mk_exp(1'b0, 0, 1'b1)};
        vecs[2] = '{7'd14, 6'd33, 1'b1, 1'b1, mk_exp(1'b0, 0, 1'b1)};
        vecs[3] = '{7'd15, 6'd32, 1'b1, 1'b1, mk_exp(1'b0, 0, 1'b1)};
        vecs[4] = '{7'd15, 6'd33, 1'b1, 1'b1, mk_exp(1'b1, 1, 1'b0)};

        repeat (3) tick();
        reset = 1'b1;
        repeat (5) tick();
        check("rst_apple_x", apple_x, 15);
        check("rst_apple_y", apple_y, 33);
        check("rst_apple_valid", apple_valid, 1);
        check("rst_score", score, 0);
        check("rst_occ_req", occ_req, 0);
        check("rst_occ_xy", {occ_x, occ_y}, 0);
        check("rst_win", win, 0);
        check("rst_board_full", board_full, 0);
        check("rst_eat_pulse", eat_pulse, 0);

        // Eat qualification table; the last vector is the first real eat.
        for (int i = 0; i < 5; i++)
            apply(vecs[i].hx, vecs[i].hy, vecs[i].tk, vecs[i].run, vecs[i].e);

        // Best-case respawn timing: req in N+2, commit in N+3, valid in N+4.
        tick();
        check("n2_occ_req", occ_req, 1);
        check("n2_eat_pulse_once", eat_pulse, 0);
        tick();
        check("n3_occ_req_drop", occ_req, 0);
        check("n3_apple_valid", apple_valid, 0);
        tick();
        check("n4_apple_valid", apple_valid, 1);
        check("first_cand_x", apple_x, cand_x(rise_lfsr[0]));
        check("first_cand_y", apple_y, cand_y(rise_lfsr[0]));
        check("apple_x_range", apple_x < 7'(TB_W), 1);
        check("apple_y_range", apple_y < 6'(TB_H), 1);

        // Eight hits exhaust random tries; the scan candidate gets committed.
        rise_lfsr.delete();
        rise_x.delete();
        rise_y.delete();
        q_count = 0;
        rsp_hits_left = 8;
        apply(apple_x, apple_y, 1'b1, 1'b1, mk_exp(1'b1, 2, 1'b0));
        wait_apple(100, c);
        check("retry_latency", 1 + c, 20);
        check("retry_queries", q_count, 9);
        check("retry_rises", rise_x.size(), 9);
        for (int i = 0; i < 8 && i < rise_x.size(); i++) begin
            check("gen_cand_x", rise_x[i], cand_x(rise_lfsr[i]));
            check("gen_cand_y", rise_y[i], cand_y(rise_lfsr[i]));
        end
        if (rise_x.size() >= 9) begin
            check("scan_cand_x", rise_x[8], adv_x(rise_x[7]));
            check("scan_cand_y", rise_y[8], adv_y(rise_x[7], rise_y[7]));
            check("scan_commit_x", apple_x, rise_x[8]);
            check("scan_commit_y", apple_y, rise_y[8]);
        end

        // Eats up to the win limit.
        for (int k = 3; k <= 10; k++) begin
            apply(apple_x, apple_y, 1'b1, 1'b1, mk_exp(1'b1, k, 1'b0));
            if (k < 10) wait_apple(40, c);
        end
        check("win_set", win, 1);
        apply(apple_x, apple_y, 1'b1, 1'b1, mk_exp(1'b0, 10, 1'b0));
        repeat (3) tick();
        check("done_score_hold", score, 10);
        check("done_win_hold", win, 1);
        check("done_no_query", occ_req, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rs_score", score, 0);
        check("rs_apple_x", apple_x, 15);
        check("rs_apple_y", apple_y, 33);
        check("rs_apple_valid", apple_valid, 1);
        check("rs_win", win, 0);

        // Restart in the middle of a delayed handshake, then a late ack.
        rsp_delay = 3;
        apply(7'd15, 6'd33, 1'b1, 1'b1, mk_exp(1'b1, 1, 1'b0));
        tick();
        check("hs_req_up", occ_req, 1);
        tick();
        check("hs_req_held", occ_req, 1);
        check("hs_x_stable", occ_x, rise_x[rise_x.size() - 1]);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("hs_req_drop", occ_req, 0);
        check("hs_rs_score", score, 0);
        check("hs_rs_valid", apple_valid, 1);
        rsp_force_ack = 1'b1;
        occ_ack = 1'b1;
        occ_hit = 1'b0;
        repeat (2) tick();
        rsp_force_ack = 1'b0;
        check("late_ack_x", apple_x, 15);
        check("late_ack_y", apple_y, 33);
        check("late_ack_valid", apple_valid, 1);
        check("late_ack_req", occ_req, 0);
        rsp_delay = 0;

        // Board-full on the 64x32 instance with every cell occupied.
        s_head_x    = 7'd15;
        s_head_y    = 6'd33;
        s_game_run  = 1'b1;
        s_move_tick = 1'b1;
        s_q_count   = 0;
        tick();
        s_move_tick = 1'b0;
        s_watch     = 1'b1;
        check("s_eat_pulse", s_eat_pulse, 1);
        c = 0;
        while (!s_board_full && c < 6000) begin
            tick();
            c++;
        end
        check("s_board_full", s_board_full, 1);
        check("s_queries", s_q_count, 8 + 2048);
        check("s_valid_stays_0", s_valid_seen, 0);
        check("s_req_idle", s_occ_req, 0);
        s_move_tick = 1'b1;
        tick();
        s_move_tick = 1'b0;
        check("s_eat_ignored_pulse", s_eat_pulse, 0);
        check("s_eat_ignored_score", s_score, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apple_spawn_ctrl.md
# apple_spawn_ctrl

Game-level controller for the apple resource on the snake grid. It detects when the snake head reaches the apple on a movement step, then keeps the score with a win limit. It also sequences respawn of the apple at a free grid cell: an LFSR proposes candidate cells, each candidate is checked through an occupancy-query handshake with the snake body store, and the controller falls back to a linear scan when random tries run out. It sits between the snake movement logic, the body store and the renderer, and owns `apple_x/apple_y/score`.

## Interface
Parameters:
- `GRID_W`, default 80: grid columns. Legal range 64..128.
- `GRID_H`, default 60: grid rows. Legal range 32..64.
- `MAX_TRIES`, default 8: number of random candidates tried before the fallback scan. Legal range 1..15.
- `WIN_SCORE`, default 10: score at which the game is won. Legal range 1..15.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset. Assertion (0) clears immediately; release is synchronous to `clk`.
- `restart`, in, 1: synchronous new-game pulse. Overrides every other input.
- `game_run`, in, 1: eat detection is enabled only while this is 1.
- `move_tick`, in, 1: one-cycle strobe issued when the snake has stepped.
- `head_x`, in, 7: head column, sampled on `move_tick`.
- `head_y`, in, 6: head row, sampled on `move_tick`.
- `occ_req`, out, 1: occupancy query valid.
- `occ_x`, out, 7: queried column.
- `occ_y`, out, 6: queried row.
- `occ_ack`, in, 1: query answered.
- `occ_hit`, in, 1: queried cell is occupied by the snake. Valid only when `occ_ack`=1.
- `apple_x`, out, 7: apple column.
- `apple_y`, out, 6: apple row.
- `apple_valid`, out, 1: apple is placed and drawable.
- `score`, out, 4: apples eaten.
- `eat_pulse`, out, 1: one-cycle grow request to the snake.
- `win`, out, 1: sticky; set when `score` reaches `WIN_SCORE`.
- `board_full`, out, 1: sticky; set when no free cell exists.

## Operation
- Reset values: `apple_x`=15, `apple_y`=33, `apple_valid`=1, `score`=0, `eat_pulse`=0, `win`=0, `board_full`=0, `occ_req`=0, `occ_x`=0, `occ_y`=0. State is IDLE, try counter 0, scan counter 0, LFSR=`LFSR_SEED`.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts every cycle, free-running, regardless of state.
- Candidate generation from the LFSR:
  - cx = `lfsr[6:0]`; if cx ≥ `GRID_W`, subtract `GRID_W` once.
  - cy = `lfsr[13:8]`; if cy ≥ `GRID_H`, subtract `GRID_H` once.
  - The legal parameter ranges guarantee one subtraction is enough.
- States:
  - IDLE: waits for an eat condition.
  - GEN: latches a random candidate and increments the try counter.
  - CHECK: runs the occupancy handshake on the candidate.
  - SCAN: advances the candidate by one cell.
  - COMMIT: writes the free candidate to the apple outputs.
  - DONE: game won; nothing further happens.
  - FULL: no free cell exists; nothing further happens.
- Eat condition, evaluated in IDLE only: `move_tick` & `game_run` & `apple_valid` & (`head_x`==`apple_x`) & (`head_y`==`apple_y`).
- On an eat:
  - `eat_pulse`=1 for exactly one cycle.
  - `score`+1.
  - `apple_valid`=0.
  - Next state is DONE if the new score equals `WIN_SCORE` (with `win`=1); otherwise GEN, with the try counter cleared.
- CHECK:
  - `occ_req`=1 with `occ_x/occ_y` held stable until the `occ_ack` cycle.
  - `occ_req` falls the cycle after the ack.
  - On ack with `occ_hit`=0: go to COMMIT.
  - On ack with `occ_hit`=1: go to GEN if tries < `MAX_TRIES`, otherwise to SCAN.
- SCAN:
  - x+1; when x reaches `GRID_W`-1 it wraps to 0 and y+1; y wraps from `GRID_H`-1 to 0.
  - The scan counter is incremented, then CHECK follows.
  - When the scan counter reaches `GRID_W`×`GRID_H` (14-bit counter): set `board_full`=1 and go to FULL.
- COMMIT: `apple_x/apple_y` take the candidate, `apple_valid`=1, the scan counter clears, and the state returns to IDLE.
- `move_tick` outside IDLE is ignored: no eat, no score change.
- `restart` (any state, including mid-handshake):
  - all outputs return to their reset values in the next cycle; `occ_req` drops.
  - The LFSR is not reseeded.
  - A late `occ_ack` after restart is ignored.
- `score` never exceeds `WIN_SCORE`; DONE blocks further increments.

## Timing
- Eat latency: `move_tick` in cycle N gives `eat_pulse`, the new `score` and `apple_valid`=0 in N+1.
- The GEN cycle is N+1 and `occ_req` rises in N+2.
- Best-case respawn: ack in the same cycle `occ_req` rises (N+2), COMMIT in N+3, `apple_valid`=1 in N+4.
- Each extra random try costs 2 cycles plus the ack wait.
- Each scan step costs 2 cycles plus the ack wait.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Release reset and idle for 5 cycles -> `apple_x`=15, `apple_y`=33, `apple_valid`=1, `score`=0, `occ_req`=0, `win`=0.
- Head at (15,33) with `move_tick`, `game_run`=1, `occ_ack` tied high with `occ_hit`=0 -> `eat_pulse` for 1 cycle in N+1, `score`=1, `apple_valid`=1 in N+4, new apple equal to the bench LFSR model's candidate and inside 0..79 / 0..59.
- Respond `occ_hit`=1 for 8 queries, then 0 -> 8 GEN candidates, then a scan candidate equal to the 8th candidate +1 in x with wrap, which is committed.
- `occ_hit` always 1 with `GRID_W`=64 and `GRID_H`=32 -> `board_full`=1 after 8+2048 queries, `apple_valid` stays 0, and later eats are ignored.
- Ten eats -> `score`=10, `win`=1, state DONE, an 11th `move_tick` at the apple changes nothing; `restart` -> `score`=0, apple (15,33), `win`=0.
- `restart` while `occ_req`=1 and the ack is delayed 3 cycles -> `occ_req`=0 the next cycle, the late ack is ignored, and the apple is (15,33) valid.
